gray_position_tracker: RTL and testbench
========================================

GRAY_POSITION_TRACKER -- requirements
Module: gray_position_tracker

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the consecutive-cycle count for debounce acceptance (legal range 2..15).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 gray_in  input  4  SHALL carry an asynchronous 4-bit Gray-coded position (sensor or upstream binary_to_gray output).
REQ-005 clear  input  1  SHALL be a synchronous request to zero pos (and err_cnt when compiled in).
REQ-006 bin_out  output  4  SHALL hold the binary decode of the last accepted code.
REQ-007 pos  output  8  SHALL hold the unsigned accumulated position count.
REQ-008 step_up  output  1  SHALL pulse for one cycle on an accepted +1 step.
REQ-009 step_dn  output  1  SHALL pulse for one cycle on an accepted -1 step.
REQ-010 err  output  1  SHALL pulse for one cycle on an accepted illegal jump.
REQ-011 valid  output  1  SHALL be high once the first code after reset has been accepted.

Function
REQ-012 gray_in SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-013 Debounce: if sync2 != candidate, candidate<=sync2 and stable count<=0; else count increments, saturating at STABLE_CYCLES-1.
REQ-014 Acceptance SHALL occur on the edge after count reaches STABLE_CYCLES-1 if candidate differs from the accepted code or valid=0; one acceptance per distinct code.
REQ-015 Latency: with gray_in held from the edge that first samples it (edge 1), outputs SHALL update at edge STABLE_CYCLES+3 (edge 7 at default).
REQ-016 Decode: b[3]=g[3], b[i]=b[i+1] XOR g[i] for i=2..0.
REQ-017 First acceptance with valid=0: bin_out<=decode, valid<=1, no step/err pulse, pos unchanged.
REQ-018 Later acceptance: delta=(new-bin_out) mod 16; delta=1 -> step_up, pos+1; delta=15 -> step_dn, pos-1; otherwise err, pos unchanged.
REQ-019 bin_out SHALL update to the new decode on every acceptance, including err (resync).
REQ-020 pos SHALL wrap modulo 256 (255+1=0, 0-1=255).
REQ-021 clear SHALL force pos<=0, overriding a simultaneous step's pos update; step/err pulses and bin_out still update that cycle.
REQ-022 Glitches shorter than STABLE_CYCLES cycles at sync2 SHALL produce no acceptance and no output change.
REQ-023 At most one of step_up, step_dn, err SHALL be high in any cycle.

Reset
REQ-024 rst high SHALL immediately clear sync1, sync2, candidate, count, bin_out, pos, step_up, step_dn, err, valid (and err_cnt) to 0, regardless of clk.
REQ-025 Reset asserted mid-debounce SHALL discard the pending code; first acceptance after release follows REQ-017.

Configuration
REQ-026 With macro GRAY_ERR_CNT_EN defined, output err_cnt (8 bits) SHALL exist, increment on each err pulse, saturate at 255, and clear on rst or clear.
REQ-027 Without GRAY_ERR_CNT_EN, err_cnt port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 Reset then gray_in=4'b0000 held -> at edge 7 valid=1, bin_out=0, pos=0, no pulses.
REQ-029 Gray sequence 0000,0001,0011,0010 each held 10 cycles -> three step_up pulses, pos=3, bin_out=3.
REQ-030 From bin_out=0, gray_in=4'b1000 (binary 15) held -> one step_dn, pos=255; then 4'b0110 (binary 4) held -> err pulse, pos=255, bin_out=4, err_cnt=1 with GRAY_ERR_CNT_EN.
REQ-031 From stable 0000, 3-cycle glitch to 0001 then back -> no pulses, pos and bin_out unchanged.
REQ-032 clear asserted in the acceptance cycle of a +1 step -> step_up=1 that cycle, pos=0 next.
REQ-033 rst pulsed mid-debounce of a new code -> all outputs 0 asynchronously; held code then accepted as first code, no step.

Source files
------------

// File: rtl/gray_position_tracker.sv
// Debounced Gray-code position tracker: synchronizes and debounces a 4-bit Gray input,
// then turns accepted +/-1 steps into an 8-bit position. Optional macro GRAY_ERR_CNT_EN adds err_cnt.
module gray_position_tracker #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] gray_in,
    input  logic       clear,
    output logic [3:0] bin_out,
    output logic [7:0] pos,
    output logic       step_up,
    output logic       step_dn,
    output logic       err,
`ifdef GRAY_ERR_CNT_EN
    output logic [7:0] err_cnt,
`endif
    output logic       valid
);

    localparam int unsigned CODE_W = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned POS_W  = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [CODE_W-1:0] sync1;
    logic [CODE_W-1:0] sync2;
    logic [CODE_W-1:0] candidate;
    logic [CNT_W-1:0]  count;

    logic [CODE_W-1:0] cand_bin;
    logic [CODE_W-1:0] delta;
    logic              accept;
    logic              is_up;
    logic              is_dn;
    logic              is_err;
    logic [POS_W-1:0]  pos_next;

    function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
        logic [CODE_W-1:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    // Acceptance needs a candidate that has been stable long enough and is new (or the first one).
    always_comb begin
        cand_bin = gray2bin(candidate);
        delta    = CODE_W'(cand_bin - bin_out);
        accept   = (count == CNT_MAX) && (sync2 == candidate) &&
                   (!valid || (cand_bin != bin_out));
        is_up    = valid && (delta == 4'd1);
        is_dn    = valid && (delta == 4'hF);
        is_err   = valid && !is_up && !is_dn;

        pos_next = pos;
        if (clear) begin
            pos_next = '0;
        end else if (accept && is_up) begin
            pos_next = POS_W'(pos + 8'd1);
        end else if (accept && is_dn) begin
            pos_next = POS_W'(pos - 8'd1);
        end
    end

    // Synchronizer and debounce counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            candidate <= '0;
            count     <= '0;
        end else begin
            sync1 <= gray_in;
            sync2 <= sync1;
            if (sync2 != candidate) begin
                candidate <= sync2;
                count     <= '0;
            end else if (count != CNT_MAX) begin
                count <= CNT_W'(count + 4'd1);
            end
        end
    end

    // Registered outputs; pulses last one cycle by default.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_out <= '0;
            pos     <= '0;
            step_up <= 1'b0;
            step_dn <= 1'b0;
            err     <= 1'b0;
            valid   <= 1'b0;
        end else begin
            pos     <= pos_next;
            step_up <= accept && is_up;
            step_dn <= accept && is_dn;
            err     <= accept && is_err;
            if (accept) begin
                bin_out <= cand_bin;
                valid   <= 1'b1;
            end
        end
    end

`ifdef GRAY_ERR_CNT_EN
    // Saturating count of accepted illegal jumps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (clear) begin
            err_cnt <= '0;
        end else if (accept && is_err && (err_cnt != 8'hFF)) begin
            err_cnt <= POS_W'(err_cnt + 8'd1);
        end
    end
`endif

endmodule

// File: tb/tb_gray_position_tracker.sv
// Directed bench for gray_position_tracker with a scoreboard of expected acceptance events.
module tb_gray_position_tracker;

    localparam int unsigned S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [3:0] gray_in;
    logic [3:0] bin_out;
    logic [7:0] pos;
    logic       step_up;
    logic       step_dn;
    logic       err;
    logic       valid;
`ifdef GRAY_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    gray_position_tracker #(.STABLE_CYCLES(S)) dut (
        .clk     (clk),
        .rst     (rst),
        .gray_in (gray_in),
        .clear   (clear),
        .bin_out (bin_out),
        .pos     (pos),
        .step_up (step_up),
        .step_dn (step_dn),
        .err     (err),
`ifdef GRAY_ERR_CNT_EN
        .err_cnt (err_cnt),
`endif
        .valid   (valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       up;
        logic       dn;
        logic       er;
        logic [7:0] pos;
        logic [3:0] bin;
    } ev_t;

    ev_t        q[$];
    int         compared   = 0;
    int         mismatched = 0;
    logic       m_valid;
    logic [3:0] m_bin;
    logic [7:0] m_pos;
    logic [7:0] m_ecnt;
    logic       prev_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] bin2gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reference model: push the event the DUT must produce once code b is accepted.
    task automatic expect_code(input logic [3:0] b, input logic clr);
        ev_t        e;
        logic [3:0] d;
        e = '0;
        if (!m_valid) begin
            m_valid = 1'b1;
        end else if (b != m_bin) begin
            d = b - m_bin;
            if (d == 4'd1) begin
                e.up  = 1'b1;
                m_pos = m_pos + 8'd1;
            end else if (d == 4'hF) begin
                e.dn  = 1'b1;
                m_pos = m_pos - 8'd1;
            end else begin
                e.er = 1'b1;
                if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
            end
        end else begin
            return;
        end
        if (clr) begin
            m_pos  = 8'd0;
            m_ecnt = 8'd0;
        end
        m_bin = b;
        e.pos = m_pos;
        e.bin = b;
        q.push_back(e);
    endtask

    // Advance one edge, sample #1 later, and retire any acceptance event against the scoreboard.
    task automatic tick();
        ev_t obs;
        ev_t e;
        @(posedge clk);
        #1;
        if ((step_up || step_dn || err || (valid && !prev_valid))) begin
            obs = {step_up, step_dn, err, pos, bin_out};
            if (q.size() == 0) begin
                check("unexpected_event", 32'(obs), 32'h0);
            end else begin
                e = q.pop_front();
                check("event", 32'(obs), 32'(e));
            end
            check("onehot", 32'(int'(step_up) + int'(step_dn) + int'(err) <= 1), 32'd1);
        end
        prev_valid = valid;
    endtask

    task automatic hold(input logic [3:0] b, input int n);
        gray_in = bin2gray(b);
        expect_code(b, 1'b0);
        repeat (n) tick();
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; gray_in = 4'b0000;
        m_valid = 1'b0; m_bin = 4'd0; m_pos = 8'd0; m_ecnt = 8'd0; prev_valid = 1'b0;
        #12;
        check("reset_outputs", {23'd0, bin_out, pos, step_up, step_dn, err, valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // First code after reset: accepted silently.
        expect_code(4'd0, 1'b0);
        repeat (7) tick();
        check("first_valid", {20'd0, valid, step_up, step_dn, err, pos, bin_out}, {20'd0, 4'b1000, 8'd0, 4'd0});
        repeat (3) tick();

        // Up steps 1..3 then down to 0.
        hold(4'd1, 10); hold(4'd2, 10); hold(4'd3, 10);
        check("up_pos", 32'(pos), 32'd3);
        check("up_bin", 32'(bin_out), 32'd3);
        hold(4'd2, 10); hold(4'd1, 10); hold(4'd0, 10);
        // 0 -> 15 is a down step with wrap; 15 -> 4 is an illegal jump.
        hold(4'd15, 10);
        check("dn_wrap_pos", 32'(pos), 32'd255);
        hold(4'd4, 10);
        check("err_pos", 32'(pos), 32'd255);
        check("err_bin", 32'(bin_out), 32'd4);
`ifdef GRAY_ERR_CNT_EN
        check("err_cnt", 32'(err_cnt), 32'(m_ecnt));
`endif
        hold(4'd5, 10);
        check("up_wrap_pos", 32'(pos), 32'd0);

        // Exact latency: change seen at edge 1, outputs move at edge S+3.
        gray_in = bin2gray(4'd6);
        expect_code(4'd6, 1'b0);
        repeat (S + 2) tick();
        check("lat_before", {28'd0, step_up, bin_out[2:0]}, {28'd0, 1'b0, 3'd5});
        tick();
        check("lat_at", {28'd0, step_up, bin_out[2:0]}, {28'd0, 1'b1, 3'd6});
        repeat (3) tick();

        // Short glitch must be ignored.
        gray_in = bin2gray(4'd7);
        repeat (S - 1) tick();
        gray_in = bin2gray(4'd6);
        repeat (12) tick();
        check("glitch_pos", 32'(pos), 32'(m_pos));
        check("glitch_bin", 32'(bin_out), 32'd6);

        // clear in the acceptance cycle of a +1 step.
        gray_in = bin2gray(4'd7);
        expect_code(4'd7, 1'b1);
        repeat (S + 2) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_step", 32'(step_up), 32'd1);
        check("clear_pos", 32'(pos), 32'd0);
`ifdef GRAY_ERR_CNT_EN
        check("clear_err_cnt", 32'(err_cnt), 32'd0);
`endif
        repeat (3) tick();

        // Asynchronous reset during debounce of a new code.
        gray_in = bin2gray(4'd8);
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", {23'd0, bin_out, pos, step_up, step_dn, err, valid}, 32'd0);
        m_valid = 1'b0; m_bin = 4'd0; m_pos = 8'd0; m_ecnt = 8'd0; prev_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        expect_code(4'd8, 1'b0);
        repeat (12) tick();
        check("post_rst", {19'd0, valid, pos, bin_out}, {19'd0, 1'b1, 8'd0, 4'd8});

        check("queue_drain", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
